m16_orbit_rx: RTL

- Receive-side counterpart of the M16 Orbita telemetry serializer.
- Consumes the 1-bit Orbita stream: 12-bit words, MSB first, CLK_PER_BIT clocks per bit.
- Recovers bit and word timing, locks to the phrase marker pattern, then to group and cycle markers.
- Emits parallel words tagged with word-in-group, group number and 128-group cycle index; used for loopback checking and ground-side decoding.

---
 rtl/m16_pkg.sv | 24 ++
 rtl/m16_orbit_rx_if.sv | 23 ++
 rtl/m16_bit_sampler.sv | 54 +++++
 rtl/m16_orbit_rx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/m16_pkg.sv
// rtl/m16_pkg.sv - shared constants, FSM state and phrase-match helper for the Orbita receiver
package m16_pkg;

  localparam logic [31:0] PHR_MASK      = 32'h4504_0154;
  localparam logic [31:0] PHR_K16       = 32'h0001_0000;
  localparam logic [7:0]  GRP_END_NORM  = 8'b0111_0010;
  localparam logic [7:0]  GRP_END_LAST  = 8'b1000_1101;
  localparam logic [10:0] CYC_WORD      = 11'd240;
  localparam int          WORDS_PER_GRP = 2048;
  localparam logic [10:0] LAST_WRD      = 11'(WORDS_PER_GRP - 1);
  localparam logic [4:0]  LAST_GRP      = 5'd31;

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCK
  } m16_state_e;

  // Word 16 of a phrase carries group/cycle markers, so it never takes part in phrase matching.
  function automatic logic phr_match(input logic [31:0] v);
    return (v & ~PHR_K16) == PHR_MASK;
  endfunction

endpackage

// File: rtl/m16_orbit_rx_if.sv
// rtl/m16_orbit_rx_if.sv - serial input and tagged word output bundle of the Orbita receiver
interface m16_orbit_rx_if;

  logic        iOrbit;
  logic [11:0] oWord;
  logic        oVal;
  logic [10:0] oWrdIdx;
  logic [4:0]  oGrp;
  logic [6:0]  oCyc;
  logic [3:0]  oLock;
  logic [15:0] oErrCnt;

  modport master (
    input  iOrbit,
    output oWord, oVal, oWrdIdx, oGrp, oCyc, oLock, oErrCnt
  );

  modport slave (
    output iOrbit,
    input  oWord, oVal, oWrdIdx, oGrp, oCyc, oLock, oErrCnt
  );

endinterface

// File: rtl/m16_bit_sampler.sv
// rtl/m16_bit_sampler.sv - input synchronizer with edge-realigned bit-phase counter and mid-bit sample strobe
module m16_bit_sampler
  import m16_pkg::*;
#(
  parameter int CLK_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic stb,
  output logic bit_o
);

  localparam int CW = $clog2(CLK_PER_BIT);

  logic          s1_q, s2_q, s3_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stb_q, stb_d;
  logic          bit_q, bit_d;

  // Any synchronized transition re-centres the sampling point on the new bit.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (s2_q != s3_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(CLK_PER_BIT - 1)) begin
      cnt_d = '0;
    end
    stb_d = (cnt_d == CW'(CLK_PER_BIT / 2 - 1));
    bit_d = s2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      s3_q  <= 1'b0;
      cnt_q <= '0;
      stb_q <= 1'b0;
      bit_q <= 1'b0;
    end else begin
      s1_q  <= din;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      cnt_q <= cnt_d;
      stb_q <= stb_d;
      bit_q <= bit_d;
    end
  end

  assign stb   = stb_q;
  assign bit_o = bit_q;

endmodule

// File: rtl/m16_orbit_rx.sv
// rtl/m16_orbit_rx.sv - Orbita serial receiver: phrase/group/cycle lock and tagged word output
module m16_orbit_rx
  import m16_pkg::*;
#(
  parameter int CLK_PER_BIT = 4,
  parameter int CONFIRM_N   = 2,
  parameter int MISS_N      = 3
) (
  input  logic          iClkOrb,
  input  logic          reset,
  m16_orbit_rx_if.master bus
);

  logic smp_stb, smp_bit;

  m16_bit_sampler #(.CLK_PER_BIT(CLK_PER_BIT)) u_smp (
    .clk   (iClkOrb),
    .rst   (reset),
    .din   (bus.iOrbit),
    .stb   (smp_stb),
    .bit_o (smp_bit)
  );

  m16_state_e  state_q, state_d;
  logic [382:0] hist_q, hist_d;
  logic [3:0]  bit_idx_q, bit_idx_d;
  logic [4:0]  k_q, k_d;
  logic [10:0] sh_q, sh_d;
  logic [31:0] msb_vec_q, msb_vec_d;
  logic [3:0]  good_q, good_d;
  logic [3:0]  miss_q, miss_d;
  logic [7:0]  h_q, h_d;
  logic [10:0] wrd_ctr_q, wrd_ctr_d;
  logic [4:0]  grp_ctr_q, grp_ctr_d;
  logic [6:0]  cyc_ctr_q, cyc_ctr_d;
  logic [11:0] word_q, word_d;
  logic        val_q, val_d;
  logic [10:0] wrd_idx_q, wrd_idx_d;
  logic [4:0]  grp_q, grp_d;
  logic [6:0]  cyc_q, cyc_d;
  logic [3:0]  lock_q, lock_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic [383:0] hist_w;
  logic [31:0]  tap_vec;
  logic [11:0]  cur_word;
  logic [7:0]   h_next;
  logic         word_done, phr_end, phr_good, is_norm, is_last, lose;
  logic [3:0]   lock_n;
  logic [10:0]  wi;
  logic [4:0]   g;
  logic [6:0]   c;

  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    bit_idx_d = bit_idx_q;
    k_d       = k_q;
    sh_d      = sh_q;
    msb_vec_d = msb_vec_q;
    good_d    = good_q;
    miss_d    = miss_q;
    h_d       = h_q;
    wrd_ctr_d = wrd_ctr_q;
    grp_ctr_d = grp_ctr_q;
    cyc_ctr_d = cyc_ctr_q;
    word_d    = word_q;
    val_d     = 1'b0;
    wrd_idx_d = wrd_idx_q;
    grp_d     = grp_q;
    cyc_d     = cyc_q;
    lock_d    = lock_q;
    err_cnt_d = err_cnt_q;

    hist_w = {hist_q, smp_bit};
    for (int i = 0; i < 32; i++) begin
      tap_vec[i] = hist_w[383 - 12 * i];
    end
    cur_word  = {sh_q, smp_bit};
    word_done = smp_stb && (bit_idx_q == 4'd11);
    phr_end   = word_done && (k_q == 5'd31);
    phr_good  = phr_match(msb_vec_q);
    h_next    = {h_q[6:0], msb_vec_q[16]};
    is_norm   = (h_next == GRP_END_NORM);
    is_last   = (h_next == GRP_END_LAST);
    lose      = 1'b0;
    lock_n    = lock_q;
    wi        = wrd_ctr_q;
    g         = grp_ctr_q;
    c         = cyc_ctr_q;

    if (smp_stb) begin
      hist_d    = hist_w[382:0];
      sh_d      = {sh_q[9:0], smp_bit};
      bit_idx_d = word_done ? 4'd0 : bit_idx_q + 4'd1;
      if (word_done) k_d = k_q + 5'd1;
      if (bit_idx_q == 4'd0) msb_vec_d[k_q] = smp_bit;
      if (phr_end) h_d = h_next;
    end

    case (state_q)
      SEARCH: begin
        if (smp_stb && phr_match(tap_vec)) begin
          state_d   = VERIFY;
          bit_idx_d = 4'd0;
          k_d       = 5'd0;
          good_d    = 4'd0;
          h_d       = 8'd0;
        end
      end
      VERIFY: begin
        if (phr_end) begin
          if (!phr_good) begin
            state_d = SEARCH;
          end else if (good_q + 4'd1 >= 4'(CONFIRM_N)) begin
            state_d = LOCK;
            lock_d  = 4'b0001;
            miss_d  = 4'd0;
          end else begin
            good_d = good_q + 4'd1;
          end
        end
      end
      LOCK: begin
        if (phr_end && !phr_good) begin
          if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
          if (miss_q + 4'd1 >= 4'(MISS_N)) lose = 1'b1;
          else miss_d = miss_q + 4'd1;
        end else if (phr_end) begin
          miss_d = 4'd0;
        end

        if (word_done) begin
          wrd_ctr_d = wrd_ctr_q + 11'd1;
          if (lock_q[2] && (wrd_ctr_q == CYC_WORD)) begin
            if (cur_word[11]) begin
              cyc_ctr_d = 7'd0;
              c         = 7'd0;
              lock_n[3] = 1'b1;
            end else if (lock_q[3] && (cyc_ctr_q == 7'd0)) begin
              lock_n[3] = 1'b0;
            end
          end
          // Group-end patterns only show up in the k16 history at a phrase boundary.
          if (phr_end) begin
            if (is_norm || is_last) begin
              wi        = LAST_WRD;
              wrd_ctr_d = 11'd0;
              lock_n[1] = 1'b1;
              cyc_ctr_d = cyc_ctr_q + 7'd1;
              if (lock_q[2] && (is_last != (grp_ctr_q == LAST_GRP))) begin
                lock_n[3:2] = 2'b00;
                grp_ctr_d   = grp_ctr_q + 5'd1;
              end else if (is_last) begin
                lock_n[2] = 1'b1;
                g         = LAST_GRP;
                grp_ctr_d = 5'd0;
              end else begin
                grp_ctr_d = grp_ctr_q + 5'd1;
              end
            end else if (lock_q[1] && (wrd_ctr_q == LAST_WRD)) begin
              lock_n[3:1] = 3'b000;
            end
          end

          if (lose) begin
            state_d = SEARCH;
            lock_d  = 4'b0000;
          end else begin
            val_d     = 1'b1;
            word_d    = cur_word;
            wrd_idx_d = wi;
            grp_d     = g;
            cyc_d     = c;
            lock_d    = lock_n;
          end
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge iClkOrb) begin
    if (reset) begin
      state_q   <= SEARCH;
      hist_q    <= '0;
      bit_idx_q <= '0;
      k_q       <= '0;
      sh_q      <= '0;
      msb_vec_q <= '0;
      good_q    <= '0;
      miss_q    <= '0;
      h_q       <= '0;
      wrd_ctr_q <= '0;
      grp_ctr_q <= '0;
      cyc_ctr_q <= '0;
      word_q    <= '0;
      val_q     <= 1'b0;
      wrd_idx_q <= '0;
      grp_q     <= '0;
      cyc_q     <= '0;
      lock_q    <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      bit_idx_q <= bit_idx_d;
      k_q       <= k_d;
      sh_q      <= sh_d;
      msb_vec_q <= msb_vec_d;
      good_q    <= good_d;
      miss_q    <= miss_d;
      h_q       <= h_d;
      wrd_ctr_q <= wrd_ctr_d;
      grp_ctr_q <= grp_ctr_d;
      cyc_ctr_q <= cyc_ctr_d;
      word_q    <= word_d;
      val_q     <= val_d;
      wrd_idx_q <= wrd_idx_d;
      grp_q     <= grp_d;
      cyc_q     <= cyc_d;
      lock_q    <= lock_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.oWord   = word_q;
  assign bus.oVal    = val_q;
  assign bus.oWrdIdx = wrd_idx_q;
  assign bus.oGrp    = grp_q;
  assign bus.oCyc    = cyc_q;
  assign bus.oLock   = lock_q;
  assign bus.oErrCnt = err_cnt_q;

endmodule
